// File: rtl/bram_port_arbiter.sv
// Shares one data-memory BRAM port between the CPU datapath and a device master.
// Optional build macro MEM_ARB_CPU_PRI_EN: fixed CPU priority with a device anti-starvation counter.

module bram_port_arbiter #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 16,
  parameter int MAX_BURST = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_wait,
  input  logic              dev_req,
  input  logic              dev_we,
  input  logic [ADDR_W-1:0] dev_addr,
  input  logic [DATA_W-1:0] dev_wdata,
  output logic              dev_gnt,
  output logic              dev_rvalid,
  output logic [DATA_W-1:0] dev_rdata,
  input  logic              dev_lock,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int         STAGES = 2;
  localparam logic [7:0] MAX_B  = 8'(MAX_BURST);

  typedef enum logic [1:0] {IDLE, SHARED, DEV_BURST} state_t;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  state_t            state;
  logic              rr_dev;      // 1: device wins the next contended grant
  logic [7:0]        burst_cnt;
  logic [7:0]        burst_nxt;
  req_t              cpu_r, dev_r, sel_r;
  logic              gnt_any;
  logic [STAGES:1]   vld_pipe, rd_pipe, dev_pipe;
  logic [DATA_W-1:0] cpu_hold, dev_hold;

  assign cpu_r     = {cpu_we, cpu_addr, cpu_wdata};
  assign dev_r     = {dev_we, dev_addr, dev_wdata};
  assign sel_r     = cpu_gnt ? cpu_r : dev_r;
  assign gnt_any   = cpu_gnt | dev_gnt;
  assign burst_nxt = burst_cnt + 8'd1;
  assign cpu_wait  = cpu_req & ~cpu_gnt;

`ifdef MEM_ARB_CPU_PRI_EN
  logic [2:0] starv_cnt;

  // Counts back-to-back contended CPU wins; at 4 the device is owed a slot.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                          starv_cnt <= '0;
    else if (dev_gnt)                                    starv_cnt <= '0;
    else if (cpu_gnt && dev_req && state != DEV_BURST)   starv_cnt <= starv_cnt + 3'd1;
  end
`endif

  always_comb begin
    cpu_gnt = 1'b0;
    dev_gnt = 1'b0;
    if (state == DEV_BURST) begin
      dev_gnt = dev_req;
      cpu_gnt = cpu_req & ~dev_req;
    end else if (cpu_req && dev_req) begin
`ifdef MEM_ARB_CPU_PRI_EN
      if (starv_cnt == 3'd4) dev_gnt = 1'b1;
      else                   cpu_gnt = 1'b1;
`else
      if (rr_dev) dev_gnt = 1'b1;
      else        cpu_gnt = 1'b1;
`endif
    end else begin
      cpu_gnt = cpu_req;
      dev_gnt = dev_req;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      rr_dev    <= 1'b0;
      burst_cnt <= '0;
    end else begin
      case (state)
        IDLE, SHARED: begin
          if (gnt_any) rr_dev <= cpu_gnt;
          if (dev_gnt && dev_lock && MAX_B != 8'd1) begin
            state     <= DEV_BURST;
            burst_cnt <= 8'd1;
          end else if (cpu_req || dev_req) begin
            state <= SHARED;
          end else begin
            state <= IDLE;
          end
        end
        DEV_BURST: begin
          // Exit once the grant that reaches MAX_BURST is issued, so the count never overshoots.
          if (dev_gnt && dev_lock && burst_nxt != MAX_B) begin
            burst_cnt <= burst_nxt;
          end else begin
            state     <= SHARED;
            rr_dev    <= 1'b0;
            burst_cnt <= '0;
          end
        end
        default: begin
          state     <= IDLE;
          rr_dev    <= 1'b0;
          burst_cnt <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_addr  <= '0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
    end else begin
      mem_we <= 1'b0;
      if (gnt_any) begin
        mem_addr  <= sel_r.addr;
        mem_we    <= sel_r.we;
        mem_wdata <= sel_r.wdata;
      end
    end
  end

  // Tag pipeline: stage 1 tracks the cycle mem_* is driven, stage 2 the cycle mem_rdata is valid.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_pipe <= '0;
      rd_pipe  <= '0;
      dev_pipe <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:1], gnt_any};
      rd_pipe  <= {rd_pipe[STAGES-1:1],  gnt_any & ~sel_r.we};
      dev_pipe <= {dev_pipe[STAGES-1:1], dev_gnt};
    end
  end

  assign cpu_rvalid = vld_pipe[STAGES] & rd_pipe[STAGES] & ~dev_pipe[STAGES];
  assign dev_rvalid = vld_pipe[STAGES] & rd_pipe[STAGES] &  dev_pipe[STAGES];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cpu_hold <= '0;
      dev_hold <= '0;
    end else begin
      if (cpu_rvalid) cpu_hold <= mem_rdata;
      if (dev_rvalid) dev_hold <= mem_rdata;
    end
  end

  // Live BRAM data while the return is valid, last returned word otherwise.
  assign cpu_rdata = cpu_rvalid ? mem_rdata : cpu_hold;
  assign dev_rdata = dev_rvalid ? mem_rdata : dev_hold;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Scoreboard bench for bram_port_arbiter with a write-first BRAM model.
// Grant/return expectations are queued by stimulus and popped by a monitor.

module tb_bram_port_arbiter;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cpu_req = 0, cpu_we = 0, dev_req = 0, dev_we = 0, dev_lock = 0;
  logic [15:0] cpu_addr = 0, cpu_wdata = 0, dev_addr = 0, dev_wdata = 0;
  logic        cpu_gnt, cpu_rvalid, cpu_wait, dev_gnt, dev_rvalid, mem_we;
  logic [15:0] cpu_rdata, dev_rdata, mem_addr, mem_wdata;
  logic [15:0] mem_rdata = 16'h0;
  logic [15:0] mem [0:255];

  typedef struct {
    int          cyc;
    bit          dev;
    bit          wt;
    logic [15:0] d;
  } exp_t;

  exp_t gq[$];
  exp_t rq[$];
  exp_t me;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

`ifdef MEM_ARB_CPU_PRI_EN
  bit [5:0] cont_pat = 6'b010000;  // bit i = 1: device wins cycle i
  bit [1:0] drop_pat = 2'b00;
`else
  bit [5:0] cont_pat = 6'b101010;
  bit [1:0] drop_pat = 2'b10;
`endif

  bram_port_arbiter #(.DATA_W(16), .ADDR_W(16), .MAX_BURST(8)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata), .cpu_wait(cpu_wait),
    .dev_req(dev_req), .dev_we(dev_we), .dev_addr(dev_addr), .dev_wdata(dev_wdata),
    .dev_gnt(dev_gnt), .dev_rvalid(dev_rvalid), .dev_rdata(dev_rdata), .dev_lock(dev_lock),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Write-first synchronous BRAM
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
    mem_rdata <= mem_we ? mem_wdata : mem[mem_addr[7:0]];
  end

  always @(negedge clk) begin
    if (cpu_gnt || dev_gnt) begin
      n_cmp++;
      if (gq.size() == 0) begin
        n_bad++;
        $display("FAIL grant: unexpected cpu_gnt=%0b dev_gnt=%0b at cyc %0d, required no grant", cpu_gnt, dev_gnt, cyc);
      end else begin
        me = gq.pop_front();
        if ((cpu_gnt && dev_gnt) || me.cyc != cyc || me.dev != dev_gnt || me.wt != cpu_wait) begin
          n_bad++;
          $display("FAIL grant: cyc=%0d cpu_gnt=%0b dev_gnt=%0b wait=%0b, required cyc=%0d dev=%0b wait=%0b",
                   cyc, cpu_gnt, dev_gnt, cpu_wait, me.cyc, me.dev, me.wt);
        end
      end
    end
    if (cpu_rvalid || dev_rvalid) begin
      n_cmp++;
      if (rq.size() == 0) begin
        n_bad++;
        $display("FAIL rvalid: unexpected cpu_rvalid=%0b dev_rvalid=%0b at cyc %0d, required none", cpu_rvalid, dev_rvalid, cyc);
      end else begin
        me = rq.pop_front();
        if ((cpu_rvalid && dev_rvalid) || me.cyc != cyc || me.dev != dev_rvalid ||
            (dev_rvalid ? dev_rdata : cpu_rdata) != me.d) begin
          n_bad++;
          $display("FAIL rdata: cyc=%0d cpu_rv=%0b dev_rv=%0b cpu=%h dev=%h, required cyc=%0d dev=%0b data=%h",
                   cyc, cpu_rvalid, dev_rvalid, cpu_rdata, dev_rdata, me.cyc, me.dev, me.d);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // g: 0 no grant, 1 CPU, 2 device. rexp queues a read return with data ed.
  task automatic cyc_go(input bit cr, input bit cw, input logic [15:0] ca, input logic [15:0] cd,
                        input bit dr, input bit dw, input logic [15:0] da, input logic [15:0] dd,
                        input bit lk, input int g, input bit rexp, input logic [15:0] ed);
    exp_t e;
    cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
    dev_req = dr; dev_we = dw; dev_addr = da; dev_wdata = dd; dev_lock = lk;
    if (g != 0) begin
      e.cyc = cyc; e.dev = (g == 2); e.wt = cr && (g == 2); e.d = 16'h0;
      gq.push_back(e);
      if (rexp) begin
        e.cyc = cyc + 2; e.d = ed; e.wt = 1'b0;
        rq.push_back(e);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc_go(0,0,0,0, 0,0,0,0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'hA000 + 16'(i);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mem_we", 32'(mem_we), 0);
    chk("rst_mem_addr", 32'(mem_addr), 0);
    chk("rst_mem_wdata", 32'(mem_wdata), 0);
    chk("rst_rvalid", {30'b0, cpu_rvalid, dev_rvalid}, 0);
    chk("rst_rdata", {cpu_rdata, dev_rdata}, 0);
    reset = 1'b1;

    // Reset while a CPU read is in flight: the return must be dropped
    cyc_go(1,0,16'h0033,0, 0,0,0,0, 0, 1, 0, 0);
    cpu_req = 1'b0;
    #2 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    chk("midrst_mem_we", 32'(mem_we), 0);
    chk("midrst_mem_addr", 32'(mem_addr), 0);
    idle(3);
    chk("midrst_idle_addr", 32'(mem_addr), 0);

    // CPU alone: write then read back
    cyc_go(1,1,16'h0010,16'hBEEF, 0,0,0,0, 0, 1, 0, 0);
    chk("wr_mem_we", 32'(mem_we), 1);
    chk("wr_mem_addr", 32'(mem_addr), 32'h10);
    chk("wr_mem_wdata", 32'(mem_wdata), 32'hBEEF);
    cyc_go(1,0,16'h0010,0, 0,0,0,0, 0, 1, 1, 16'hBEEF);
    chk("rd_mem_we", 32'(mem_we), 0);
    idle(3);
    chk("idle_addr_hold", 32'(mem_addr), 32'h10);

    // Contention from a fresh reset
    do_reset();
    for (int i = 0; i < 6; i++)
      cyc_go(1,0,16'h0020,0, 1,0,16'h0040,0, 0, cont_pat[i] ? 2 : 1, 1,
             cont_pat[i] ? 16'hA040 : 16'hA020);
    idle(2);

    // Locked device burst, CPU waiting from the second cycle
    cyc_go(0,0,0,0, 1,0,16'h0040,0, 1, 2, 1, 16'hA040);
    for (int i = 1; i < 8; i++)
      cyc_go(1,0,16'h0020,0, 1,0,16'h0040,0, 1, 2, 1, 16'hA040);
    cyc_go(1,0,16'h0020,0, 1,0,16'h0040,0, 1, 1, 1, 16'hA020);
    idle(2);
    chk("burst_cnt_clear", 32'(dut.burst_cnt), 0);

    // dev_lock dropped after three burst grants
    cyc_go(0,0,0,0, 1,0,16'h0041,0, 1, 2, 1, 16'hA041);
    cyc_go(1,0,16'h0021,0, 1,0,16'h0041,0, 1, 2, 1, 16'hA041);
    cyc_go(1,0,16'h0021,0, 1,0,16'h0041,0, 1, 2, 1, 16'hA041);
    cyc_go(1,0,16'h0021,0, 1,0,16'h0041,0, 0, 2, 1, 16'hA041);
    cyc_go(1,0,16'h0021,0, 1,0,16'h0041,0, 0, 1, 1, 16'hA021);
    cyc_go(1,0,16'h0021,0, 1,0,16'h0041,0, 0, drop_pat[1] ? 2 : 1, 1,
           drop_pat[1] ? 16'hA041 : 16'hA021);
    idle(2);
    chk("burst_cnt_drop", 32'(dut.burst_cnt), 0);

    // Device write followed by CPU read of the same word
    cyc_go(0,0,0,0, 1,1,16'h0050,16'h1234, 0, 2, 0, 0);
    cyc_go(1,0,16'h0050,0, 0,0,0,0, 0, 1, 1, 16'h1234);
    idle(4);
    chk("rdata_hold", 32'(cpu_rdata), 32'h1234);

    chk("grant_queue_empty", gq.size(), 0);
    chk("read_queue_empty", rq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
